data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Arbitrates a CPU requester and a loader/DMA requester onto one shared
//   single-port data memory. Each access takes three cycles:
//   IDLE (arbitrate and latch) -> ACCESS (one memory strobe) -> RESP (one-cycle ack).
//
// Ports
//   clock, reset          : single clock, synchronous active-low reset
//   cpu_req/we/addr/wdata : CPU request, held until cpu_ack is sampled high
//   cpu_ack, cpu_rdata    : CPU completion pulse and registered read data
//   dma_*                 : same set of ports for the loader/DMA requester
//   mem_addr/we/re/wdata  : shared memory command, strobes only in ACCESS
//   mem_rdata             : combinational read data from the memory
//   busy                  : high whenever the FSM is not in IDLE
//
// Configuration
//   DATA_MEM_ARB_RR_EN    : when defined, ties are resolved round-robin using a
//                           last-grant register. When undefined, the CPU always
//                           wins ties (fixed priority).
module data_mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t        state;

    // Transaction fields latched at the grant; owner is 1 for DMA, 0 for CPU.
    logic          owner;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;

`ifdef DATA_MEM_ARB_RR_EN
    logic          last_dma;
`endif

    // Winner selection for the current IDLE cycle.
    logic          pick_dma;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    always_comb begin
        pick_dma = dma_req && !cpu_req;
`ifdef DATA_MEM_ARB_RR_EN
        // On a tie the requester that was not granted last wins.
        if (cpu_req && dma_req) begin
            pick_dma = !last_dma;
        end
`endif
    end

    assign sel_we    = pick_dma ? dma_we    : cpu_we;
    assign sel_addr  = pick_dma ? dma_addr  : cpu_addr;
    assign sel_wdata = pick_dma ? dma_wdata : cpu_wdata;

    // The memory address/data are the latched fields themselves, so they are
    // stable through ACCESS and hold their last values afterwards.
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
`ifdef DATA_MEM_ARB_RR_EN
            last_dma  <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        state     <= ACCESS;
                        busy      <= 1'b1;
                        owner     <= pick_dma;
                        lat_we    <= sel_we;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        // Strobes are registered here so they are high for
                        // exactly the ACCESS cycle.
                        mem_we    <= sel_we;
                        mem_re    <= !sel_we;
`ifdef DATA_MEM_ARB_RR_EN
                        last_dma  <= pick_dma;
`endif
                    end
                end
                ACCESS: begin
                    state  <= RESP;
                    mem_re <= 1'b0;
                    mem_we <= 1'b0;
                    if (!lat_we) begin
                        if (owner) begin
                            dma_rdata <= mem_rdata;
                        end else begin
                            cpu_rdata <= mem_rdata;
                        end
                    end
                    cpu_ack <= !owner;
                    dma_ack <= owner;
                end
                RESP: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                    mem_re  <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios followed by
// randomized transactions, checked against a transaction-level model
// (reference memory, expected rdata registers, tie-winner rule).
module tb_data_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic        dma_ack;
    logic [31:0] dma_rdata;
    logic [31:0] mem_addr;
    logic        mem_re, mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    data_mem_arbiter #(.AW(32), .DW(32)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    // Memory attached to the DUT (written only through the DUT strobes).
    bit [31:0] mem_arr [0:255];
    always @(posedge clock) begin
        if (mem_we && mem_addr < 32'd256) mem_arr[mem_addr[7:0]] <= mem_wdata;
    end
    assign mem_rdata = (mem_addr < 32'd256) ? mem_arr[mem_addr[7:0]] : 32'hBAD0_BAD0;

    // Reference model state.
    bit [31:0]   ref_mem [0:255];
    logic [31:0] exp_cpu = '0;
    logic [31:0] exp_dma = '0;
`ifdef DATA_MEM_ARB_RR_EN
    bit          last_dma = 1'b1;
`endif

    int total  = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit tie_winner();
`ifdef DATA_MEM_ARB_RR_EN
        return !last_dma;
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input bit own, input bit we, input logic [31:0] a, input logic [31:0] d);
        if (own) begin
            dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        end
    endtask

    // Called at the negedge just before the grant edge; ends at the negedge of
    // the RESP cycle with the owner's request dropped.
    task automatic serve(input bit own, input bit we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        // Disturb the owner's inputs after the grant; the transaction must not notice.
        if (own) begin
            dma_addr = a + 32'h10; dma_wdata = ~d; dma_we = !we;
            if ($urandom_range(0, 3) == 0) dma_req = 1'b0;
        end else begin
            cpu_addr = a + 32'h10; cpu_wdata = ~d; cpu_we = !we;
            if ($urandom_range(0, 3) == 0) cpu_req = 1'b0;
        end
        check("access_re", mem_re, !we);
        check("access_we", mem_we, we);
        check("access_addr", mem_addr, a);
        if (we) check("access_wdata", mem_wdata, d);
        check("access_busy", busy, 1);
        check("access_acks", {cpu_ack, dma_ack}, 0);
        if (we) ref_mem[a[7:0]] = d;
        else if (own) exp_dma = ref_mem[a[7:0]];
        else exp_cpu = ref_mem[a[7:0]];
        @(negedge clock);
        check("resp_strobes", {mem_re, mem_we}, 0);
        check("resp_cpu_ack", cpu_ack, !own);
        check("resp_dma_ack", dma_ack, own);
        check("resp_cpu_rdata", cpu_rdata, exp_cpu);
        check("resp_dma_rdata", dma_rdata, exp_dma);
        check("resp_addr_hold", mem_addr, a);
        if (own) dma_req = 1'b0; else cpu_req = 1'b0;
`ifdef DATA_MEM_ARB_RR_EN
        last_dma = own;
`endif
    endtask

    task automatic idle_check();
        @(negedge clock);
        check("idle_busy", busy, 0);
        check("idle_strobes", {mem_re, mem_we}, 0);
        check("idle_acks", {cpu_ack, dma_ack}, 0);
    endtask

    task automatic transact(input bit c_on, input bit d_on,
                            input bit cwe, input logic [31:0] ca, input logic [31:0] cd,
                            input bit dwe, input logic [31:0] da, input logic [31:0] dd);
        bit first;
        if (c_on) drive(1'b0, cwe, ca, cd);
        if (d_on) drive(1'b1, dwe, da, dd);
        first = (c_on && d_on) ? tie_winner() : d_on;
        if (first) serve(1'b1, dwe, da, dd); else serve(1'b0, cwe, ca, cd);
        idle_check();
        if (c_on && d_on) begin
            if (first) serve(1'b0, cwe, ca, cd); else serve(1'b1, dwe, da, dd);
            idle_check();
        end
    endtask

    initial begin
        bit own;
        // Reset state.
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_acks", {cpu_ack, dma_ack}, 0);
        check("rst_strobes", {mem_re, mem_we}, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_dma_rdata", dma_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        reset = 1'b1;
        idle_check();

        // CPU write then read of 0x10; the read also has cpu_addr moved to 0x20 in ACCESS.
        transact(1, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0);
        transact(1, 0, 0, 32'h10, 32'h0, 0, 0, 0);
        check("cpu_rd_deadbeef", cpu_rdata, 32'hDEADBEEF);
        check("dma_rd_untouched", dma_rdata, 0);

        // DMA read of 0x4 while cpu_rdata holds 0xCAFEF00D.
        transact(1, 0, 1, 32'h8, 32'hCAFEF00D, 0, 0, 0);
        transact(1, 0, 0, 32'h8, 32'h0, 0, 0, 0);
        transact(0, 1, 0, 0, 0, 1, 32'h4, 32'h12345678);
        transact(0, 1, 0, 0, 0, 0, 32'h4, 32'h0);
        check("dma_rd_12345678", dma_rdata, 32'h12345678);
        check("cpu_rd_kept", cpu_rdata, 32'hCAFEF00D);

        // Simultaneous requests: winner then loser, ack at the 2nd and 5th cycle.
        transact(1, 1, 0, 32'h4, 0, 0, 32'h10, 0);

        // Both requesters held continuously for four grants.
        drive(1'b0, 1'b0, 32'h8, 32'h0);
        drive(1'b1, 1'b0, 32'h4, 32'h0);
        for (int k = 0; k < 4; k++) begin
            own = tie_winner();
            if (own) serve(1'b1, 1'b0, 32'h4, 32'h0); else serve(1'b0, 1'b0, 32'h8, 32'h0);
            @(negedge clock);
            check("hold_idle_busy", busy, 0);
            if (k < 3) begin
                if (own) drive(1'b1, 1'b0, 32'h4, 32'h0); else drive(1'b0, 1'b0, 32'h8, 32'h0);
            end else begin
                cpu_req = 1'b0; dma_req = 1'b0;
            end
        end
        idle_check();

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            int mode;
            mode = $urandom_range(0, 2);
            transact(mode != 1, mode != 0,
                     1'($urandom), 32'($urandom_range(0, 255)), $urandom,
                     1'($urandom), 32'($urandom_range(0, 255)), $urandom);
        end

        // Reset during ACCESS of a DMA write aborts the transaction.
        drive(1'b1, 1'b1, 32'h30, 32'hA5A5A5A5);
        @(negedge clock);
        check("abort_access_we", mem_we, 1);
        reset = 1'b0;
        dma_req = 1'b0;
        ref_mem[8'h30] = 32'hA5A5A5A5;
        exp_cpu = '0;
        exp_dma = '0;
`ifdef DATA_MEM_ARB_RR_EN
        last_dma = 1'b1;
`endif
        @(negedge clock);
        check("abort_dma_ack", dma_ack, 0);
        check("abort_strobes", {mem_re, mem_we}, 0);
        check("abort_busy", busy, 0);
        check("abort_rdata", {cpu_rdata, dma_rdata}, 0);
        check("abort_mem_bus", {mem_addr, mem_wdata}, 0);
        reset = 1'b1;
        idle_check();
        idle_check();

        // Traffic after the abort, including a read of the aborted address.
        transact(0, 1, 0, 0, 0, 0, 32'h30, 32'h0);
        transact(1, 1, 0, 32'h10, 0, 0, 32'h8, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL timeout: observed no completion expected $finish");
    end

endmodule
